hps_ps2_tx: RTL and testbench

Multi-channel PS/2 device-side transmitter for the HPS I/O path. It takes bytes written by the HPS command decoder, such as keyboard (0x05) or mouse (0x04) payloads, and queues them in per-channel FIFOs. Each queued byte is serialised as an 11-bit PS/2 frame on a shared, divided PS/2 clock. It supersedes the fixed two-channel, 8-deep, fire-and-forget transmitters with parametrised channel count and depth, overflow reporting, fill status, and host-inhibit abort with retransmission.

---
 rtl/hps_ps2_pkg.sv | 23 ++
 rtl/hps_ps2_chan.sv | 131 +++++++++++++
 rtl/hps_ps2_tx.sv | 70 +++++++
 tb/tb_hps_ps2_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_ps2_pkg.sv
// Shared definitions for the HPS PS/2 device-side transmitter.
// Serialiser states are numbered so D0..D7 are consecutive.
package hps_ps2_pkg;

  typedef logic [3:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE  = 4'd0;
  localparam ps2_state_t ST_START = 4'd1;
  localparam ps2_state_t ST_D0    = 4'd2;
  localparam ps2_state_t ST_D1    = 4'd3;
  localparam ps2_state_t ST_D2    = 4'd4;
  localparam ps2_state_t ST_D3    = 4'd5;
  localparam ps2_state_t ST_D4    = 4'd6;
  localparam ps2_state_t ST_D5    = 4'd7;
  localparam ps2_state_t ST_D6    = 4'd8;
  localparam ps2_state_t ST_D7    = 4'd9;
  localparam ps2_state_t ST_PAR   = 4'd10;
  localparam ps2_state_t ST_STOP  = 4'd11;

  localparam int PS2_FRAME_TICKS = 12;
  localparam int CH_SEL_W        = 2;

endpackage

// File: rtl/hps_ps2_chan.sv
// One PS/2 transmit channel: byte FIFO plus 11-bit frame serialiser.
// The head byte is only popped once its stop bit is on the line, so an abort resends it.
module hps_ps2_chan
  import hps_ps2_pkg::*;
#(
  parameter int FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       clk_ps2,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       inhibit,
  input  logic       ovf_clr,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int                   DEPTH    = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0]   FULL_CNT = (FIFO_BITS + 1)'(DEPTH);

  logic [7:0]           mem [DEPTH];
  logic [FIFO_BITS-1:0] rptr, wptr;
  logic [FIFO_BITS:0]   count;
  logic                 push, pop;

  ps2_state_t state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       par, par_nxt;
  logic       data_q, data_nxt;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  // Fullness is judged before any same-cycle pop, so a write to a full FIFO always drops.
  assign push       = wr_en & ~fifo_full;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (wr_en && fifo_full) overflow <= 1'b1;
      else if (ovf_clr)       overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      data_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
    end
  end

  always_ff @(posedge clk_sys) begin
    shreg <= shreg_nxt;
    par   <= par_nxt;
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    par_nxt   = par;
    data_nxt  = data_q;
    pop       = 1'b0;
    if (tick) begin
      if (inhibit && state != ST_IDLE) begin
        state_nxt = ST_IDLE;
        data_nxt  = 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!fifo_empty && !inhibit) begin
              shreg_nxt = mem[rptr];
              par_nxt   = 1'b1;
              data_nxt  = 1'b0;
              state_nxt = ST_START;
            end
          end
          ST_START, ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_D6: begin
            data_nxt  = shreg[0];
            shreg_nxt = {1'b0, shreg[7:1]};
            par_nxt   = par ^ shreg[0];
            state_nxt = state + 4'd1;
          end
          ST_D7: begin
            data_nxt  = par;
            state_nxt = ST_PAR;
          end
          ST_PAR: begin
            data_nxt  = 1'b1;
            state_nxt = ST_STOP;
          end
          ST_STOP: begin
            data_nxt  = 1'b1;
            pop       = 1'b1;
            state_nxt = ST_IDLE;
          end
          default: begin
            data_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    ps2_clk  = clk_ps2 | (state == ST_IDLE);
    ps2_data = data_q;
  end

endmodule

// File: rtl/hps_ps2_tx.sv
// Multi-channel PS/2 device-side transmitter: shared clock divider, write
// decode and one FIFO/serialiser per channel.
module hps_ps2_tx
  import hps_ps2_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 1000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                wr,
  input  logic [CH_SEL_W-1:0] wr_ch,
  input  logic [7:0]          wr_data,
  input  logic [NUM_CH-1:0]   inhibit,
  input  logic [NUM_CH-1:0]   ovf_clr,
  output logic [NUM_CH-1:0]   fifo_full,
  output logic [NUM_CH-1:0]   fifo_empty,
  output logic [NUM_CH-1:0]   overflow,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   ps2_clk,
  output logic [NUM_CH-1:0]   ps2_data
);

  localparam int CNT_W = (PS2DIV > 0) ? $clog2(PS2DIV + 1) : 1;

  logic [CNT_W-1:0] cnt;
  logic             clk_ps2;
  logic             div_wrap;
  logic             tick;

  assign div_wrap = (cnt == CNT_W'(PS2DIV));
  // Frames advance on the rising edge of the shared PS/2 clock.
  assign tick     = div_wrap & ~clk_ps2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      clk_ps2 <= 1'b0;
    end else if (div_wrap) begin
      cnt     <= '0;
      clk_ps2 <= ~clk_ps2;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

  // Channel selects at or above NUM_CH match no instance and are discarded.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hps_ps2_chan #(
      .FIFO_BITS (FIFO_BITS)
    ) u_chan (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .tick       (tick),
      .clk_ps2    (clk_ps2),
      .wr_en      (wr && (wr_ch == CH_SEL_W'(i))),
      .wr_data    (wr_data),
      .inhibit    (inhibit[i]),
      .ovf_clr    (ovf_clr[i]),
      .fifo_full  (fifo_full[i]),
      .fifo_empty (fifo_empty[i]),
      .overflow   (overflow[i]),
      .busy       (busy[i]),
      .ps2_clk    (ps2_clk[i]),
      .ps2_data   (ps2_data[i])
    );
  end

endmodule

// File: tb/tb_hps_ps2_tx.sv
// Scoreboard bench for hps_ps2_tx: stimulus queues expected bytes per channel,
// a monitor rebuilds each frame from ps2_data on divider ticks and compares.
module tb_hps_ps2_tx;

  localparam int NUM_CH    = 2;
  localparam int FIFO_BITS = 3;
  localparam int PS2DIV    = 4;
  localparam int DEPTH     = 1 << FIFO_BITS;
  localparam int TICK_PER  = 2 * (PS2DIV + 1);

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              wr;
  logic [1:0]        wr_ch;
  logic [7:0]        wr_data;
  logic [NUM_CH-1:0] inhibit, ovf_clr;
  logic [NUM_CH-1:0] fifo_full, fifo_empty, overflow, busy, ps2_clk, ps2_data;

  hps_ps2_tx #(.NUM_CH(NUM_CH), .FIFO_BITS(FIFO_BITS), .PS2DIV(PS2DIV)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .wr         (wr),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .inhibit    (inhibit),
    .ovf_clr    (ovf_clr),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .busy       (busy),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data)
  );

  always #5 clk_sys = ~clk_sys;

  int n_pass = 0;
  int n_chk  = 0;
  int edge_n = 0;

  // Reference model: per-channel byte queue (ring) with the edge each byte was written.
  logic [7:0]  mb  [NUM_CH][DEPTH];
  int          mw  [NUM_CH][DEPTH];
  int          mh  [NUM_CH];
  int          ms  [NUM_CH];
  int          pos [NUM_CH];
  logic [7:0]  cur [NUM_CH];
  logic [10:0] obs [NUM_CH];
  logic        ovf_exp [NUM_CH];

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[ch%0d]: got %0h, expected %0h (t=%0t)", nm, c, act, exp, $time);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~(^b), b, 1'b0};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      mh[c] = 0; ms[c] = 0; pos[c] = 0; ovf_exp[c] = 1'b0; obs[c] = '0; cur[c] = '0;
    end
    edge_n = 0;
  endtask

  task automatic tick_model(input int c, input logic inh, input int t);
    if (pos[c] == 0) begin
      if (!inh && ms[c] > 0 && mw[c][mh[c]] < t) begin
        pos[c] = 1;
        cur[c] = mb[c][mh[c]];
        obs[c] = '0;
        obs[c][0] = ps2_data[c];
      end
    end else if (inh) begin
      pos[c] = 0;
    end else begin
      pos[c] = pos[c] + 1;
      if (pos[c] <= 11) obs[c][pos[c]-1] = ps2_data[c];
      else begin
        chk("frame", c, 32'(obs[c]), 32'(frame_of(cur[c])));
        mh[c] = (mh[c] + 1) % DEPTH;
        ms[c] = ms[c] - 1;
        pos[c] = 0;
      end
    end
  endtask

  always @(posedge clk_sys) begin : mon
    int t;
    int ph;
    logic [NUM_CH-1:0] inh_s;
    if (reset_n) begin
      t = edge_n;
      edge_n = edge_n + 1;
      inh_s = inhibit;
      #1;
      ph = t % TICK_PER;
      if (ph == PS2DIV)
        for (int c = 0; c < NUM_CH; c++) tick_model(c, inh_s[c], t);
      for (int c = 0; c < NUM_CH; c++) begin
        chk("busy", c, 32'(busy[c]), 32'(pos[c] != 0));
        chk("ps2_clk", c, 32'(ps2_clk[c]),
            32'((pos[c] == 0) || (ph >= PS2DIV && ph <= 2 * PS2DIV)));
        if (pos[c] == 0) chk("idle_data", c, 32'(ps2_data[c]), 32'd1);
        chk("fifo_empty", c, 32'(fifo_empty[c]), 32'(ms[c] == 0));
        chk("fifo_full", c, 32'(fifo_full[c]), 32'(ms[c] == DEPTH));
        chk("overflow", c, 32'(overflow[c]), 32'(ovf_exp[c]));
      end
    end
  end

  task automatic nxt();
    @(negedge clk_sys);
    wr = 1'b0;
    ovf_clr = '0;
  endtask

  task automatic drive(input logic w, input logic [1:0] ch, input logic [7:0] d,
                       input logic [NUM_CH-1:0] clr);
    int ci;
    logic [NUM_CH-1:0] set;
    ci = int'(ch);
    set = '0;
    wr = w; wr_ch = ch; wr_data = d; ovf_clr = clr;
    if (w && ci < NUM_CH) begin
      if (ms[ci] == DEPTH) set[ci] = 1'b1;
      else begin
        mb[ci][(mh[ci] + ms[ci]) % DEPTH] = d;
        mw[ci][(mh[ci] + ms[ci]) % DEPTH] = edge_n;
        ms[ci] = ms[ci] + 1;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (set[c]) ovf_exp[c] = 1'b1;
      else if (clr[c]) ovf_exp[c] = 1'b0;
    end
  endtask

  task automatic wait_pos(input int c, input int p);
    int k;
    k = 0;
    while (pos[c] != p && k < 400) begin nxt(); k++; end
    if (k >= 400) begin
      n_chk++;
      $display("FAIL wait_pos[ch%0d]: never reached phase %0d, stuck at %0d", c, p, pos[c]);
    end
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int c = 0; c < NUM_CH; c++) s += ms[c] + pos[c];
    return s;
  endfunction

  task automatic drain();
    int k;
    k = 0;
    while (pending() != 0 && k < 4000) begin nxt(); k++; end
    if (k >= 4000) begin
      n_chk++;
      $display("FAIL drain: queues not empty after %0d cycles, pending %0d", k, pending());
    end
    repeat (3) nxt();
  endtask

  task automatic check_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      chk("rst_data", c, 32'(ps2_data[c]), 32'd1);
      chk("rst_clk", c, 32'(ps2_clk[c]), 32'd1);
      chk("rst_busy", c, 32'(busy[c]), 32'd0);
      chk("rst_empty", c, 32'(fifo_empty[c]), 32'd1);
      chk("rst_full", c, 32'(fifo_full[c]), 32'd0);
      chk("rst_ovf", c, 32'(overflow[c]), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b1; wr = 1'b0; wr_ch = '0; wr_data = '0; inhibit = '0; ovf_clr = '0;
    model_clear();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_reset();
    reset_n = 1'b1;

    // Single byte on ch0; ch1 must stay idle-high.
    nxt(); drive(1'b1, 2'd0, 8'h1C, '0);
    drain();

    // Back-to-back bytes on ch1.
    nxt(); drive(1'b1, 2'd1, 8'h00, '0);
    nxt(); drive(1'b1, 2'd1, 8'hFF, '0);
    drain();

    // Fill ch0 while inhibited, then overflow and clear.
    inhibit[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin nxt(); drive(1'b1, 2'd0, 8'(8'h10 + i), '0); end
    nxt();
    chk("full_after_8", 0, 32'(fifo_full[0]), 32'd1);
    drive(1'b1, 2'd0, 8'hEE, '0);
    repeat (4) nxt();
    chk("ovf_sticky", 0, 32'(overflow[0]), 32'd1);
    drive(1'b0, 2'd0, 8'h00, 2'b01);
    nxt(); nxt();
    chk("ovf_cleared", 0, 32'(overflow[0]), 32'd0);

    // Write landing on the STOP pop of a full FIFO.
    inhibit[0] = 1'b0;
    wait_pos(0, 11);
    while ((edge_n % TICK_PER) != PS2DIV) nxt();
    drive(1'b1, 2'd0, 8'h77, '0);
    nxt();
    chk("stop_pop_ovf", 0, 32'(overflow[0]), 32'd1);
    chk("stop_pop_notfull", 0, 32'(fifo_full[0]), 32'd0);
    drive(1'b0, 2'd0, 8'h00, 2'b01);
    drain();

    // Inhibit during D3 of 0xA5, then full resend.
    nxt(); drive(1'b1, 2'd0, 8'hA5, '0);
    wait_pos(0, 5);
    inhibit[0] = 1'b1;
    wait_pos(0, 0);
    chk("abort_data", 0, 32'(ps2_data[0]), 32'd1);
    chk("abort_no_pop", 0, 32'(fifo_empty[0]), 32'd0);
    repeat (15) nxt();
    inhibit[0] = 1'b0;
    drain();

    // Randomised traffic, including channel selects beyond NUM_CH.
    for (int i = 0; i < 700; i++) begin
      logic [NUM_CH-1:0] clr;
      int ic;
      nxt();
      clr = ($urandom_range(29) == 0) ? NUM_CH'($urandom) : '0;
      if ($urandom_range(3) == 0)
        drive(1'b1, 2'($urandom_range(3)), 8'($urandom), clr);
      else
        drive(1'b0, 2'd0, 8'h00, clr);
      if ($urandom_range(39) == 0) begin
        ic = $urandom_range(NUM_CH - 1);
        inhibit[ic] = ~inhibit[ic];
      end
    end
    inhibit = '0;
    drain();

    // Asynchronous reset in the middle of a frame.
    nxt(); drive(1'b1, 2'd1, 8'h3C, '0);
    nxt(); drive(1'b1, 2'd0, 8'h5A, '0);
    wait_pos(1, 3);
    repeat (6) nxt();
    @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1 check_reset();
    model_clear();
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) nxt();
    nxt(); drive(1'b1, 2'd0, 8'h81, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
